// File: rtl/region_pkg.sv
// Shared types and defaults for the region-growing result streamer.
package region_pkg;

    localparam int DEF_ROWS   = 273;
    localparam int DEF_COLS   = 182;
    localparam int DEF_ADDR_W = $clog2(DEF_ROWS * DEF_COLS);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_R = 2'd0;
    localparam logic [1:0] SEL_G = 2'd1;
    localparam logic [1:0] SEL_B = 2'd2;

    function automatic logic [7:0] rgb_byte(input rgb_t px, input logic [1:0] sel);
        case (sel)
            SEL_R:   return px.r;
            SEL_G:   return px.g;
            default: return px.b;
        endcase
    endfunction

endpackage

// File: rtl/region_pix_buf.sv
// Two-entry pixel FIFO: the head is the pixel being serialised, the tail the prefetched one.
module region_pix_buf
    import region_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic push_i,
    input  logic pop_i,
    input  rgb_t wdata_i,
    output rgb_t head_o,
    output logic full_o,
    output logic empty_o
);

    rgb_t       mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clr_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/region_result_streamer.sv
// Streams the result frame buffer in raster order as R,G,B bytes over valid/ready
// and counts pixels with a non-zero RGB value.
module region_result_streamer
    import region_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_sof,
    output logic              m_eof,
    output logic [ADDR_W-1:0] region_count
);

    localparam int                NPIX     = ROWS * COLS;
    localparam logic [ADDR_W:0]   NPIX_C   = (ADDR_W + 1)'(NPIX);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;
    logic              resp_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W:0]   issue_cnt_q;
    logic [ADDR_W-1:0] pix_cnt_q;
    logic [ADDR_W-1:0] region_q;
    logic [1:0]        sel_q;

    logic buf_clr, buf_push, buf_pop, buf_full, buf_empty;
    rgb_t buf_head;
    logic hs, issue, frame_end;

    // resp_q marks the cycle rd_data is valid; a read is in flight while rd_en_q or resp_q is set.
    assign buf_clr   = (state_q == ST_IDLE) && start;
    assign buf_push  = resp_q;
    assign hs        = m_valid && m_ready;
    assign buf_pop   = hs && (sel_q == SEL_B);
    assign frame_end = buf_pop && (pix_cnt_q == LAST_PIX);
    assign issue     = (state_q == ST_RUN) && !buf_full && !rd_en_q && !resp_q
                       && (issue_cnt_q < NPIX_C);

    region_pix_buf u_pix_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (buf_clr),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .wdata_i (rgb_t'(rd_data)),
        .head_o  (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            resp_q      <= 1'b0;
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
            pix_cnt_q   <= '0;
            region_q    <= '0;
            sel_q       <= SEL_R;
        end else begin
            rd_en_q <= 1'b0;
            resp_q  <= rd_en_q;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= '0;
                        issue_cnt_q <= (ADDR_W + 1)'(1);
                        pix_cnt_q   <= '0;
                        region_q    <= '0;
                        sel_q       <= SEL_R;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= issue_cnt_q[ADDR_W-1:0];
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                    if (buf_push && (rd_data != 24'd0)) begin
                        region_q <= region_q + 1'b1;
                    end
                    if (hs) begin
                        sel_q <= (sel_q == SEL_B) ? SEL_R : sel_q + 2'd1;
                    end
                    if (buf_pop) begin
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                    end
                    if (frame_end) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign region_count = region_q;
    assign m_valid      = !buf_empty;
    assign m_data       = buf_empty ? 8'h00 : rgb_byte(buf_head, sel_q);
    assign m_sof        = m_valid && (pix_cnt_q == '0) && (sel_q == SEL_R);
    assign m_eof        = m_valid && (pix_cnt_q == LAST_PIX) && (sel_q == SEL_B);

endmodule
